restoring_divider_seq: RTL and testbench
========================================

Name: restoring_divider_seq

Overview:
- Sequential unsigned integer divider. It is the inverse companion of the vedic multiplier datapath.
- Computes quotient and remainder with one restoring-division step per clock.
- Start/busy/done handshake lets a controller or testbench issue one operation at a time.
- Sits beside the multiplier in the arithmetic library; output is checkable against it as q*divisor + r == dividend.

Parameters:
- WIDTH, 4, bit width of dividend, divisor, quotient and remainder (legal range 2..32).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- dividend  input  WIDTH  unsigned dividend; captured on accepted start.
- divisor  input  WIDTH  unsigned divisor; captured on accepted start.
- quotient  output  WIDTH  result quotient.
- remainder  output  WIDTH  result remainder.
- busy  output  1  high while an operation is in progress.
- done  output  1  single-cycle pulse when results become valid.
- div_by_zero  output  1  set with done when the captured divisor was 0.

Behaviour:
- Clock and reset:
  - One clock domain, clk.
  - Reset is synchronous, active-low, named rst_n. It is sampled on the clk rising edge only.
  - While rst_n=0 at an edge: state=IDLE, quotient=0, remainder=0, busy=0, done=0, div_by_zero=0, step counter=0.
- States: IDLE, CALC, DONE.
- IDLE:
  - busy=0, done=0.
  - At edge E0 with start=1: capture dividend into the shift register and divisor into the divisor register; clear the partial remainder; set counter=WIDTH.
  - Divisor nonzero: go to CALC, busy=1 from E0.
  - Divisor zero: go straight to DONE.
- CALC, one step per edge:
  - Shift {partial_rem, dividend_sr} left by 1.
  - trial = partial_rem_shifted - divisor, computed at WIDTH+1 bits.
  - trial non-negative: partial_rem=trial and shift in quotient bit 1. Otherwise keep the shifted value and shift in 0.
  - Decrement the counter; when it reaches 0, go to DONE.
  - The WIDTH steps occupy edges E1..EW.
- DONE, for exactly one cycle:
  - At entry, quotient and remainder registers are loaded; done=1 and busy=0 in that cycle.
  - Next edge: go to IDLE; done returns to 0.
- Latency: done is high in the cycle after edge E0+WIDTH (5 cycles total at WIDTH=4). Divide-by-zero: done is high in the cycle after E0+1.
- Divide-by-zero result: quotient = all ones, remainder = captured dividend, div_by_zero=1.
- div_by_zero is held until the next accepted start, which clears it.
- quotient and remainder:
  - Hold their last value until the next DONE.
  - Do not change during CALC; the working registers are internal.
- start while busy or in DONE: ignored, with no queuing. Operand changes after E0 have no effect.
- start held high continuously: a new operation is accepted on the first IDLE edge after DONE.
- rst_n low mid-CALC: the operation is aborted at that edge and all outputs go to reset values; done never pulses for the aborted operation.
- Arithmetic rule: unsigned only. The subtraction borrow is taken from bit WIDTH of the trial result.

Optional Feature:
- Macro: DIV_EARLY_EXIT_EN.
- Defined:
  - At an accepted start with divisor != 0 and dividend < divisor, skip CALC and go to DONE.
  - Result: quotient=0, remainder=dividend, done in the cycle after E0+1.
- Not defined: all nonzero-divisor operations take the full WIDTH steps.
- The result values are identical either way; only latency differs.

Decomposition:
- Shared include div_defs.vh:
  - State encodings IDLE=2'd0, CALC=2'd1, DONE=2'd2.
  - Default WIDTH.
  - Counter width function/localparam: clog2(WIDTH+1).
- One natural sub-module, div_step:
  - Purely combinational single restoring step.
  - Inputs: partial_rem, next dividend bit, divisor.
  - Outputs: new partial_rem, quotient bit.
  - Instantiated once in the CALC datapath.

Test Plan (WIDTH=4):
- 13/3, start pulse at E0 → busy high 4 cycles; done in the cycle after E0+4; quotient=4, remainder=1, div_by_zero=0.
- 15/1, then 15/15 back-to-back with start held high → q=15 r=0, then q=1 r=0. The second done is exactly 6 cycles after the first.
- 9/0 → done in the cycle after E0+1; quotient=15, remainder=9, div_by_zero=1. A following 6/2 clears the flag: q=3 r=0.
- 12/5 started, then start pulsed with 7/7 at E0+2 → second request ignored; result q=2 r=2. A single done pulse.
- 14/3 started, rst_n low for one edge at E0+2 → all outputs 0 next cycle; no done pulse; a subsequent 14/3 yields q=4 r=2.
- 2/3:
  - With DIV_EARLY_EXIT_EN: done after E0+1, q=0 r=2.
  - Without it: done after E0+4, same values.

Source files
------------

// File: rtl/restoring_divider_seq_pkg.sv
// restoring_divider_seq_pkg: shared states, default width and step-counter sizing for the divider.
package restoring_divider_seq_pkg;
    localparam int DEF_WIDTH = 4;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction
endpackage

// File: rtl/restoring_divider_seq_div_step.sv
// div_step: one combinational restoring-division step; borrow is bit WIDTH of the trial subtraction.
module div_step #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] partial_rem,
    input  logic             dividend_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] new_rem,
    output logic             q_bit
);
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;
    always_comb begin
        shifted = {partial_rem, dividend_bit};
        trial   = shifted - {1'b0, divisor};
        q_bit   = ~trial[WIDTH];
        new_rem = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    end
endmodule

// File: rtl/restoring_divider_seq.sv
// restoring_divider_seq: sequential unsigned restoring divider; DIV_EARLY_EXIT_EN skips CALC when dividend < divisor.
module restoring_divider_seq
    import restoring_divider_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);
    localparam int CW = cnt_width(WIDTH);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rmd_q, rmd_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH-1:0] step_rem;
    logic             step_q;

    div_step #(.WIDTH(WIDTH)) u_step (
        .partial_rem (rem_q),
        .dividend_bit(sr_q[WIDTH-1]),
        .divisor     (dvs_q),
        .new_rem     (step_rem),
        .q_bit       (step_q)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        sr_d    = sr_q;
        dvs_d   = dvs_q;
        quo_d   = quo_q;
        rmd_d   = rmd_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    sr_d  = dividend;
                    dvs_d = divisor;
                    rem_d = '0;
                    cnt_d = CW'(WIDTH);
                    dbz_d = 1'b0;
                    if (divisor == '0) begin
                        state_d = DONE;
                        quo_d   = '1;
                        rmd_d   = dividend;
                        dbz_d   = 1'b1;
                    end
`ifdef DIV_EARLY_EXIT_EN
                    else if (dividend < divisor) begin
                        state_d = DONE;
                        quo_d   = '0;
                        rmd_d   = dividend;
                    end
`endif
                    else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                // quotient bits fill the dividend shift register from the right
                rem_d = step_rem;
                sr_d  = {sr_q[WIDTH-2:0], step_q};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                    quo_d   = {sr_q[WIDTH-2:0], step_q};
                    rmd_d   = step_rem;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            sr_q    <= '0;
            dvs_q   <= '0;
            quo_q   <= '0;
            rmd_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            sr_q    <= sr_d;
            dvs_q   <= dvs_d;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
            dbz_q   <= dbz_d;
        end
    end

    assign quotient    = quo_q;
    assign remainder   = rmd_q;
    assign busy        = (state_q == CALC);
    assign done        = (state_q == DONE);
    assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_restoring_divider_seq.sv
// tb_restoring_divider_seq: scoreboard bench for the WIDTH=4 divider with directed vectors.
module tb_restoring_divider_seq;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] dividend = '0;
    logic [3:0] divisor = '0;
    logic [3:0] quotient, remainder;
    logic       busy, done, div_by_zero;

    typedef struct {
        logic [3:0] q;
        logic [3:0] r;
        logic       z;
        int         due;
        int         bz;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   fails = 0;
    int   busy_run = 0;

`ifdef DIV_EARLY_EXIT_EN
    localparam int EARLY_LAT = 0;
`else
    localparam int EARLY_LAT = 4;
`endif

    restoring_divider_seq #(.WIDTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .quotient   (quotient),
        .remainder  (remainder),
        .busy       (busy),
        .done       (done),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) busy_run = 0;
        else if (busy) busy_run++;
        if (done) begin
            if (sb.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_done: got done=1 expected no pulse (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("quotient", int'(quotient), int'(e.q));
                chk("remainder", int'(remainder), int'(e.r));
                chk("div_by_zero", int'(div_by_zero), int'(e.z));
                chk("done_cycle", cyc, e.due);
                chk("busy_cycles", busy_run, e.bz);
                chk("busy_in_done", int'(busy), 0);
            end
            busy_run = 0;
        end
    end

    task automatic issue(input logic [3:0] a, input logic [3:0] b, input bit push,
                         input logic [3:0] eq, input logic [3:0] er, input logic ez, input int lat);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        if (push) sb.push_back('{eq, er, ez, cyc + 1 + lat, lat});
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((sb.size() != 0 || busy || done) && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) begin
            checks++;
            fails++;
            $display("FAIL timeout: got %0d pending results expected 0", sb.size());
        end
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_quotient", int'(quotient), 0);
        chk("rst_remainder", int'(remainder), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_dbz", int'(div_by_zero), 0);
        rst_n = 1'b1;

        issue(4'd13, 4'd3, 1, 4'd4, 4'd1, 1'b0, 4);
        wait_idle();

        @(negedge clk);
        dividend = 4'd15;
        divisor  = 4'd1;
        start    = 1'b1;
        sb.push_back('{4'd15, 4'd0, 1'b0, cyc + 5, 4});
        sb.push_back('{4'd1, 4'd0, 1'b0, cyc + 11, 4});
        @(negedge clk);
        dividend = 4'd15;
        divisor  = 4'd15;
        repeat (6) @(negedge clk);
        start = 1'b0;
        wait_idle();

        issue(4'd9, 4'd0, 1, 4'd15, 4'd9, 1'b1, 0);
        wait_idle();
        chk("dbz_held", int'(div_by_zero), 1);
        chk("quotient_held", int'(quotient), 15);
        issue(4'd6, 4'd2, 1, 4'd3, 4'd0, 1'b0, 4);
        chk("dbz_cleared", int'(div_by_zero), 0);
        chk("quotient_stable_calc", int'(quotient), 15);
        chk("remainder_stable_calc", int'(remainder), 9);
        wait_idle();

        issue(4'd12, 4'd5, 1, 4'd2, 4'd2, 1'b0, 4);
        dividend = 4'd7;
        divisor  = 4'd7;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        issue(4'd14, 4'd3, 0, 4'd0, 4'd0, 1'b0, 4);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_quotient", int'(quotient), 0);
        chk("abort_remainder", int'(remainder), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        issue(4'd14, 4'd3, 1, 4'd4, 4'd2, 1'b0, 4);
        wait_idle();

        issue(4'd2, 4'd3, 1, 4'd0, 4'd2, 1'b0, EARLY_LAT);
        wait_idle();
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
